// File: rtl/vm_serial_loader_if.sv
// Valid/ready pop interface between the VM sample buffer and the serial loader.
// Each word is {ps, vat}, DATA_WIDTH bits each.
interface vm_serial_loader_if #(
    parameter int unsigned DATA_WIDTH = 6
);
    logic                      s_valid;
    logic                      s_ready;
    logic [2*DATA_WIDTH-1:0]   s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/vm_serial_loader.sv
// Serialises {phase, attenuation} words to the PS/VAT chips on each slow pulse tick and
// latches them with ser_le; reports live values, completion, underflows and tick overruns.
module vm_serial_loader #(
    parameter int unsigned DATA_WIDTH = 6,
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ctrl_rst,
    input  logic                  enable,
    input  logic                  active_mode,
    input  logic [DIV_WIDTH-1:0]  fast_clk_div,
    input  logic [DIV_WIDTH-1:0]  slow_clk_div,
    input  logic [CNT_WIDTH-1:0]  pulse_cnt,
    input  logic [DATA_WIDTH-1:0] phase_idle,
    input  logic [DATA_WIDTH-1:0] atten_idle,
    vm_serial_loader_if.slave     s_bus,
    output logic                  ser_clk,
    output logic                  ser_ps,
    output logic                  ser_vat,
    output logic                  ser_le,
    output logic [DATA_WIDTH-1:0] ps_val,
    output logic [DATA_WIDTH-1:0] vat_val,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  underflow_cnt,
    output logic                  tick_overrun
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StWait, StLoad, StShift, StLatch} state_e;

    state_e                state_q, state_d;
    logic [DIV_WIDTH-1:0]  slow_cnt_q, slow_cnt_d;
    logic [DIV_WIDTH-1:0]  hcnt_q, hcnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic                  tick_pending_q, tick_pending_d;
    logic                  overrun_q, overrun_d;
    logic                  ser_clk_q, ser_clk_d;
    logic                  done_q, done_d;
    logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] ps_sh_q, ps_sh_d, vat_sh_q, vat_sh_d;
    logic [DATA_WIDTH-1:0] ps_val_q, ps_val_d, vat_val_q, vat_val_d;
    logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d, uflow_q, uflow_d, word_inc;
    logic                  run, tick, half_done, last_bit, last_word, enter_load;

    assign run        = enable && !done_q;
    assign tick       = run && (slow_cnt_q == slow_clk_div);
    assign half_done  = (hcnt_q == div_q);
    assign last_bit   = ser_clk_q && (bit_cnt_q == BitCntW'(DATA_WIDTH - 1));
    assign word_inc   = word_cnt_q + 1'b1;
    assign last_word  = (pulse_cnt != '0) && (word_inc == pulse_cnt);
    assign enter_load = (state_q == StWait) && (state_d == StLoad);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (enable && !done_q) state_d = StWait;
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (tick_pending_q) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StShift;
            StShift: if (half_done && last_bit) state_d = StLatch;
            StLatch: begin
                if (half_done) begin
                    state_d = (!enable || last_word) ? StIdle : StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ctrl_rst) state_d = StIdle;
    end

    always_comb begin
        s_bus.s_ready = (state_q == StLoad) && active_mode && s_bus.s_valid;
        ser_le        = (state_q == StLatch);
        busy          = (state_q != StIdle);
        ser_ps        = (state_q == StShift) && ps_sh_q[DATA_WIDTH-1];
        ser_vat       = (state_q == StShift) && vat_sh_q[DATA_WIDTH-1];
    end

    always_comb begin
        slow_cnt_d     = (run && !tick) ? slow_cnt_q + 1'b1 : '0;
        tick_pending_d = tick_pending_q;
        if (enter_load) tick_pending_d = 1'b0;
        if (tick)       tick_pending_d = 1'b1;
        if (!enable)    tick_pending_d = 1'b0;
        // A tick landing on the very cycle the pending one is consumed is not an overrun.
        overrun_d  = overrun_q | (tick && tick_pending_q && !enter_load);
        hcnt_d     = hcnt_q;
        div_d      = div_q;
        ser_clk_d  = ser_clk_q;
        bit_cnt_d  = bit_cnt_q;
        ps_sh_d    = ps_sh_q;
        vat_sh_d   = vat_sh_q;
        ps_val_d   = ps_val_q;
        vat_val_d  = vat_val_q;
        word_cnt_d = word_cnt_q;
        done_d     = done_q;
        uflow_d    = uflow_q;
        case (state_q)
            StLoad: begin
                div_d     = fast_clk_div;
                hcnt_d    = '0;
                bit_cnt_d = '0;
                ser_clk_d = 1'b0;
                if (s_bus.s_ready) begin
                    {ps_sh_d, vat_sh_d} = s_bus.s_data;
                end else begin
                    ps_sh_d  = phase_idle;
                    vat_sh_d = atten_idle;
                end
                if (active_mode && !s_bus.s_valid && (uflow_q != '1)) begin
                    uflow_d = uflow_q + 1'b1;
                end
            end
            StShift: begin
                if (half_done) begin
                    hcnt_d    = '0;
                    ser_clk_d = !ser_clk_q;
                    // Rotate rather than shift: after DATA_WIDTH falls the word is back intact.
                    if (ser_clk_q) begin
                        ps_sh_d   = {ps_sh_q[DATA_WIDTH-2:0], ps_sh_q[DATA_WIDTH-1]};
                        vat_sh_d  = {vat_sh_q[DATA_WIDTH-2:0], vat_sh_q[DATA_WIDTH-1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            StLatch: begin
                if (half_done) begin
                    hcnt_d     = '0;
                    ps_val_d   = ps_sh_q;
                    vat_val_d  = vat_sh_q;
                    word_cnt_d = word_inc;
                    done_d     = done_q | last_word;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (!enable) begin
            word_cnt_d = '0;
            done_d     = 1'b0;
        end
        if (ctrl_rst) begin
            slow_cnt_d     = '0;
            tick_pending_d = 1'b0;
            overrun_d      = 1'b0;
            hcnt_d         = '0;
            div_d          = '0;
            ser_clk_d      = 1'b0;
            bit_cnt_d      = '0;
            ps_sh_d        = '0;
            vat_sh_d       = '0;
            ps_val_d       = '0;
            vat_val_d      = '0;
            word_cnt_d     = '0;
            done_d         = 1'b0;
            uflow_d        = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slow_cnt_q     <= '0;
            tick_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            hcnt_q         <= '0;
            div_q          <= '0;
            ser_clk_q      <= 1'b0;
            bit_cnt_q      <= '0;
            ps_sh_q        <= '0;
            vat_sh_q       <= '0;
            ps_val_q       <= '0;
            vat_val_q      <= '0;
            word_cnt_q     <= '0;
            done_q         <= 1'b0;
            uflow_q        <= '0;
        end else begin
            slow_cnt_q     <= slow_cnt_d;
            tick_pending_q <= tick_pending_d;
            overrun_q      <= overrun_d;
            hcnt_q         <= hcnt_d;
            div_q          <= div_d;
            ser_clk_q      <= ser_clk_d;
            bit_cnt_q      <= bit_cnt_d;
            ps_sh_q        <= ps_sh_d;
            vat_sh_q       <= vat_sh_d;
            ps_val_q       <= ps_val_d;
            vat_val_q      <= vat_val_d;
            word_cnt_q     <= word_cnt_d;
            done_q         <= done_d;
            uflow_q        <= uflow_d;
        end
    end

    assign ser_clk       = ser_clk_q;
    assign ps_val        = ps_val_q;
    assign vat_val       = vat_val_q;
    assign done          = done_q;
    assign underflow_cnt = uflow_q;
    assign tick_overrun  = overrun_q;

endmodule

// File: tb/tb_vm_serial_loader.sv
// Directed bench for vm_serial_loader: buffer source model, serial-line monitor and
// hand-computed expectations for each scenario.
module tb_vm_serial_loader;

    localparam int unsigned DW = 6;

    logic        clk, rst, ctrl_rst, enable, active_mode, sat_en;
    logic [15:0] fast_clk_div, slow_clk_div;
    logic [31:0] pulse_cnt;
    logic [5:0]  phase_idle, atten_idle;
    logic        ser_clk, ser_ps, ser_vat, ser_le, busy, done, tick_overrun;
    logic [5:0]  ps_val, vat_val;
    logic [31:0] underflow_cnt;
    logic        sat_ser_clk, sat_ser_ps, sat_ser_vat, sat_ser_le, sat_busy, sat_done, sat_ovr;
    logic [5:0]  sat_ps, sat_vat;
    logic [3:0]  sat_uflow;

    vm_serial_loader_if #(.DATA_WIDTH(DW)) bus ();
    vm_serial_loader_if #(.DATA_WIDTH(DW)) sat_bus ();

    assign sat_bus.s_valid = 1'b0;
    assign sat_bus.s_data  = '0;

    vm_serial_loader #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ctrl_rst(ctrl_rst), .enable(enable), .active_mode(active_mode),
        .fast_clk_div(fast_clk_div), .slow_clk_div(slow_clk_div), .pulse_cnt(pulse_cnt),
        .phase_idle(phase_idle), .atten_idle(atten_idle), .s_bus(bus),
        .ser_clk(ser_clk), .ser_ps(ser_ps), .ser_vat(ser_vat), .ser_le(ser_le),
        .ps_val(ps_val), .vat_val(vat_val), .busy(busy), .done(done),
        .underflow_cnt(underflow_cnt), .tick_overrun(tick_overrun)
    );

    // Narrow counter instance so underflow saturation is reachable in a short run.
    vm_serial_loader #(.DATA_WIDTH(DW), .DIV_WIDTH(16), .CNT_WIDTH(4)) sat_dut (
        .clk(clk), .rst(rst), .ctrl_rst(ctrl_rst), .enable(sat_en), .active_mode(1'b1),
        .fast_clk_div(16'd0), .slow_clk_div(16'd19), .pulse_cnt(4'd0),
        .phase_idle(phase_idle), .atten_idle(atten_idle), .s_bus(sat_bus),
        .ser_clk(sat_ser_clk), .ser_ps(sat_ser_ps), .ser_vat(sat_ser_vat), .ser_le(sat_ser_le),
        .ps_val(sat_ps), .vat_val(sat_vat), .busy(sat_busy), .done(sat_done),
        .underflow_cnt(sat_uflow), .tick_overrun(sat_ovr)
    );

    int          checks, failures;
    int unsigned cyc, pops, src_base, src_len;
    logic        src_inf;
    logic [11:0] src_mem [8];
    int unsigned load_t [64];
    int unsigned le_t [64];
    int unsigned rise_t [64];
    logic [5:0]  cap_ps_log [64];
    logic [5:0]  cap_vat_log [64];
    int unsigned le_pulses, le_cycles, rise_cnt;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Buffer model: pops are observed mid-cycle, the next word is presented after the edge.
    initial begin
        logic        popped;
        int unsigned k;
        logic [31:0] tmp;
        pops          = 0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        forever begin
            @(negedge clk);
            popped = bus.s_ready;
            if (popped && pops < 64) load_t[pops] = cyc;
            @(posedge clk);
            #1;
            if (popped) pops++;
            k = pops - src_base;
            if (src_inf) begin
                tmp         = k * 37 + 5;
                bus.s_valid = 1'b1;
                bus.s_data  = tmp[11:0];
            end else begin
                bus.s_valid = (k < src_len);
                bus.s_data  = (k < 8) ? src_mem[k[2:0]] : 12'h000;
            end
        end
    end

    // Serial-line monitor: captures bits on ser_clk rise and logs each latch pulse.
    initial begin
        logic       clk_prev, le_prev;
        logic [5:0] cap_ps, cap_vat;
        clk_prev  = 1'b0;
        le_prev   = 1'b0;
        cap_ps    = '0;
        cap_vat   = '0;
        le_pulses = 0;
        le_cycles = 0;
        rise_cnt  = 0;
        forever begin
            @(negedge clk);
            if (ser_clk && !clk_prev) begin
                cap_ps  = {cap_ps[4:0], ser_ps};
                cap_vat = {cap_vat[4:0], ser_vat};
                if (rise_cnt < 64) rise_t[rise_cnt] = cyc;
                rise_cnt++;
            end
            if (ser_le) le_cycles++;
            if (ser_le && !le_prev) begin
                if (le_pulses < 64) begin
                    le_t[le_pulses]        = cyc;
                    cap_ps_log[le_pulses]  = cap_ps;
                    cap_vat_log[le_pulses] = cap_vat;
                end
                le_pulses++;
            end
            clk_prev = ser_clk;
            le_prev  = ser_le;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_ctl"}, {24'd0, busy, done, ser_clk, ser_ps, ser_vat, ser_le,
                                 bus.s_ready, tick_overrun}, 32'd0);
        check_eq({tag, "_val"}, {20'd0, ps_val, vat_val}, 32'd0);
        check_eq({tag, "_uflow"}, underflow_cnt, 32'd0);
    endtask

    task automatic soft_reset();
        enable   = 1'b0;
        step(1);
        ctrl_rst = 1'b1;
        step(1);
        ctrl_rst = 1'b0;
        step(1);
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        while (!done && n < max) begin
            step(1);
            n++;
        end
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic wait_ready(input string tag, input int max);
        int n = 0;
        while (!bus.s_ready && n < max) begin
            step(1);
            n++;
        end
        check_eq({tag, "_pop"}, {31'd0, bus.s_ready}, 32'd1);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n = 0;
        while (busy && n < max) begin
            step(1);
            n++;
        end
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int unsigned en_cyc, b, p0, lc0;
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        ctrl_rst     = 1'b0;
        enable       = 1'b0;
        sat_en       = 1'b0;
        active_mode  = 1'b0;
        fast_clk_div = 16'd1;
        slow_clk_div = 16'd99;
        pulse_cnt    = 32'd0;
        phase_idle   = 6'h00;
        atten_idle   = 6'h00;
        src_inf      = 1'b0;
        src_len      = 0;
        src_base     = 0;
        for (int i = 0; i < 8; i++) src_mem[i] = 12'h000;
        step(3);
        check_cleared("reset");
        rst = 1'b0;
        step(2);

        // 1: three buffer words, fast=1, slow=99
        src_mem[0]  = 12'hA5C;
        src_mem[1]  = 12'h3F0;
        src_mem[2]  = 12'h001;
        src_base    = pops;
        src_len     = 3;
        pulse_cnt   = 32'd3;
        active_mode = 1'b1;
        step(2);
        enable = 1'b1;
        en_cyc = cyc;
        wait_done("t1", 1000);
        check_eq("t1_busy", {31'd0, busy}, 32'd0);
        check_eq("t1_ps_val", {26'd0, ps_val}, 32'h00);
        check_eq("t1_vat_val", {26'd0, vat_val}, 32'h01);
        check_eq("t1_pops", pops, 32'd3);
        check_eq("t1_le_pulses", le_pulses, 32'd3);
        check_eq("t1_le_cycles", le_cycles, 32'd6);
        check_eq("t1_rises", rise_cnt, 32'd18);
        check_eq("t1_w0_ps", {26'd0, cap_ps_log[0]}, 32'h29);
        check_eq("t1_w0_vat", {26'd0, cap_vat_log[0]}, 32'h1C);
        check_eq("t1_w1_ps", {26'd0, cap_ps_log[1]}, 32'h0F);
        check_eq("t1_w1_vat", {26'd0, cap_vat_log[1]}, 32'h30);
        check_eq("t1_bit_period", rise_t[1] - rise_t[0], 32'd4);
        check_eq("t1_first_load", load_t[0] - en_cyc, 32'd101);
        check_eq("t1_load_to_le", le_t[0] - load_t[0], 32'd25);
        check_eq("t1_uflow", underflow_cnt, 32'd0);
        check_eq("t1_overrun", {31'd0, tick_overrun}, 32'd0);
        soft_reset();
        check_cleared("softrst1");

        // 2: underflow sends idle word
        src_base   = pops;
        src_len    = 0;
        phase_idle = 6'h15;
        atten_idle = 6'h2A;
        pulse_cnt  = 32'd1;
        b          = le_pulses;
        p0         = pops;
        step(2);
        enable = 1'b1;
        wait_done("t2", 600);
        check_eq("t2_ps_val", {26'd0, ps_val}, 32'h15);
        check_eq("t2_vat_val", {26'd0, vat_val}, 32'h2A);
        check_eq("t2_uflow", underflow_cnt, 32'd1);
        check_eq("t2_pops", pops - p0, 32'd0);
        check_eq("t2_ser_ps", {26'd0, cap_ps_log[b]}, 32'h15);
        check_eq("t2_ser_vat", {26'd0, cap_vat_log[b]}, 32'h2A);
        soft_reset();
        check_eq("t2_uflow_clr", underflow_cnt, 32'd0);

        // 3: idle mode ignores a valid buffer
        src_mem[0]  = 12'h777;
        src_mem[1]  = 12'h123;
        src_base    = pops;
        src_len     = 2;
        active_mode = 1'b0;
        phase_idle  = 6'h0C;
        atten_idle  = 6'h33;
        pulse_cnt   = 32'd3;
        b           = le_pulses;
        p0          = pops;
        step(2);
        enable = 1'b1;
        wait_done("t3", 1000);
        check_eq("t3_pops", pops - p0, 32'd0);
        check_eq("t3_uflow", underflow_cnt, 32'd0);
        check_eq("t3_ps_val", {26'd0, ps_val}, 32'h0C);
        check_eq("t3_vat_val", {26'd0, vat_val}, 32'h33);
        check_eq("t3_le_pulses", le_pulses - b, 32'd3);
        check_eq("t3_tick_period", le_t[b+2] - le_t[b+1], 32'd100);
        soft_reset();

        // 4: word slower than tick period
        src_mem[0]   = 12'h123;
        src_mem[1]   = 12'h456;
        src_mem[2]   = 12'h789;
        src_mem[3]   = 12'hABC;
        src_base     = pops;
        src_len      = 4;
        active_mode  = 1'b1;
        fast_clk_div = 16'd9;
        slow_clk_div = 16'd9;
        pulse_cnt    = 32'd2;
        b            = le_pulses;
        p0           = pops;
        lc0          = le_cycles;
        step(2);
        enable = 1'b1;
        wait_done("t4", 1000);
        check_eq("t4_overrun", {31'd0, tick_overrun}, 32'd1);
        check_eq("t4_pops", pops - p0, 32'd2);
        check_eq("t4_le_pulses", le_pulses - b, 32'd2);
        check_eq("t4_le_cycles", le_cycles - lc0, 32'd20);
        check_eq("t4_ps_val", {26'd0, ps_val}, 32'h11);
        check_eq("t4_vat_val", {26'd0, vat_val}, 32'h16);
        check_eq("t4_w0_ps", {26'd0, cap_ps_log[b]}, 32'h04);
        check_eq("t4_w1_vat", {26'd0, cap_vat_log[b+1]}, 32'h16);
        check_eq("t4_load_to_le", le_t[b] - load_t[p0], 32'd121);
        soft_reset();
        check_eq("t4_overrun_clr", {31'd0, tick_overrun}, 32'd0);

        // 5a: enable dropped mid-shift finishes the word
        src_mem[0]   = 12'h9C3;
        src_base     = pops;
        src_len      = 4;
        fast_clk_div = 16'd1;
        slow_clk_div = 16'd19;
        pulse_cnt    = 32'd0;
        b            = le_pulses;
        p0           = pops;
        step(2);
        enable = 1'b1;
        wait_ready("t5", 200);
        step(5);
        enable = 1'b0;
        wait_idle("t5", 100);
        check_eq("t5_le_pulses", le_pulses - b, 32'd1);
        check_eq("t5_done", {31'd0, done}, 32'd0);
        check_eq("t5_ps_val", {26'd0, ps_val}, 32'h27);
        check_eq("t5_vat_val", {26'd0, vat_val}, 32'h03);
        step(60);
        check_eq("t5_pops", pops - p0, 32'd1);

        // 5b: asynchronous reset mid-shift
        enable = 1'b1;
        wait_ready("t5b", 200);
        step(5);
        rst = 1'b1;
        #1;
        check_cleared("t5_rst_async");
        step(1);
        check_cleared("t5_rst_cycle");
        enable = 1'b0;
        rst    = 1'b0;
        step(2);

        // 6: run forever for 1000 ticks; narrow instance saturates
        src_inf      = 1'b1;
        src_base     = pops;
        fast_clk_div = 16'd0;
        slow_clk_div = 16'd19;
        pulse_cnt    = 32'd0;
        active_mode  = 1'b1;
        p0           = pops;
        step(2);
        enable = 1'b1;
        sat_en = 1'b1;
        step(20018);
        check_eq("t6_pops", pops - p0, 32'd1000);
        check_eq("t6_done", {31'd0, done}, 32'd0);
        check_eq("t6_busy", {31'd0, busy}, 32'd1);
        check_eq("t6_overrun", {31'd0, tick_overrun}, 32'd0);
        check_eq("t6_uflow", underflow_cnt, 32'd0);
        check_eq("t6_ps_val", {26'd0, ps_val}, 32'h01);
        check_eq("t6_vat_val", {26'd0, vat_val}, 32'h28);
        check_eq("t6_sat_uflow", {28'd0, sat_uflow}, 32'd15);
        enable = 1'b0;
        sat_en = 1'b0;
        step(40);
        check_eq("t6_sat_ctl", {24'd0, sat_busy, sat_done, sat_ser_clk, sat_ser_ps, sat_ser_vat,
                                sat_ser_le, sat_ovr, sat_bus.s_ready}, 32'd0);
        check_eq("t6_sat_val", {20'd0, sat_ps, sat_vat}, {20'd0, 6'h0C, 6'h33});
        check_eq("t6_sat_hold", {28'd0, sat_uflow}, 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
